// File: rtl/spi_agc_sequencer.sv
// spi_agc_sequencer
// Round-robin sequencer that lets NUM_CH AGC gain loops share one SPI byte
// engine. It frames {r1w0, addr} + data, drives chip select with setup,
// hold and inter-transaction gap, bounds each engine wait with a timeout and
// returns read data / error status to the requesting channel.
//
// Optional feature: define AGC_READBACK_EN to follow every successful write
// with an internal verify read of the same address. The channel is acked
// only after the verify read, and rsp_err flags a readback mismatch.
module spi_agc_sequencer #(
   parameter int NUM_CH         = 2,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int CH_W          = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
   input  logic                spi_clk,
   input  logic                reg_reset,
   input  logic [NUM_CH-1:0]   req,
   input  logic [NUM_CH-1:0]   req_r1w0,
   input  logic [NUM_CH*7-1:0] req_addr,
   input  logic [NUM_CH*8-1:0] req_wdata,
   output logic [NUM_CH-1:0]   grant,
   output logic [NUM_CH-1:0]   ack,
   output logic [CH_W-1:0]     channel,
   output logic [7:0]          rsp_data,
   output logic                rsp_err,
   output logic                busy,
   output logic                spi_cs,
   output logic                eng_start,
   output logic [7:0]          eng_cmd,
   output logic [7:0]          eng_wdata,
   output logic                eng_r1w0,
   input  logic                eng_done,
   input  logic [7:0]          eng_rdata
);

   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARB, S_CS_SETUP, S_START, S_WAIT, S_CS_HOLD, S_GAP
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [CH_W-1:0] ptr;
   logic [15:0]     timer;
   logic            verify_phase;
   logic            verify_pend;
   logic            verify_needed;
   logic [7:0]      res_data;
   logic            res_err;

   logic            win_vld;
   logic [CH_W-1:0] win_idx;
   logic [7:0]      win_cmd;
   logic [7:0]      win_wdata;

   assign eng_r1w0 = eng_cmd[7];

   // A write that completed without error needs a verify read before the ack
`ifdef AGC_READBACK_EN
   assign verify_needed = !verify_phase && !eng_cmd[7] && !res_err;
`else
   assign verify_needed = 1'b0;
`endif

   // Round-robin pick: first requesting channel at or after the pointer
   always_comb begin
      int idx;
      idx       = 0;
      win_vld   = 1'b0;
      win_idx   = '0;
      win_cmd   = '0;
      win_wdata = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!win_vld && req[idx]) begin
            win_vld   = 1'b1;
            win_idx   = CH_W'(idx);
            win_cmd   = {req_r1w0[idx], req_addr[idx*7 +: 7]};
            win_wdata = req_wdata[idx*8 +: 8];
         end
      end
   end

   // Next-state decode for the transaction sequence
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:     if (|req) next_state = S_ARB;
         S_ARB:      next_state = win_vld ? S_CS_SETUP : S_IDLE;
         S_CS_SETUP: next_state = S_START;
         S_START:    next_state = S_WAIT;
         S_WAIT:     if (eng_done || (timer == TO_LAST)) next_state = S_CS_HOLD;
         S_CS_HOLD:  next_state = S_GAP;
         S_GAP:      if (timer == GAP_LAST) next_state = verify_pend ? S_CS_SETUP : S_IDLE;
         default:    next_state = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge spi_clk or negedge reg_reset) begin
      if (!reg_reset) state <= S_IDLE;
      else            state <= next_state;
   end

   // Registered outputs, latched command fields, timer and response capture
   always_ff @(posedge spi_clk or negedge reg_reset) begin
      if (!reg_reset) begin
         grant        <= '0;
         ack          <= '0;
         channel      <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         busy         <= 1'b0;
         spi_cs       <= 1'b1;
         eng_start    <= 1'b0;
         eng_cmd      <= '0;
         eng_wdata    <= '0;
         ptr          <= '0;
         timer        <= '0;
         verify_phase <= 1'b0;
         verify_pend  <= 1'b0;
         res_data     <= '0;
         res_err      <= 1'b0;
      end else begin
         grant     <= '0;
         ack       <= '0;
         eng_start <= (next_state == S_START);
         spi_cs    <= !(next_state inside {S_CS_SETUP, S_START, S_WAIT, S_CS_HOLD});
         busy      <= (next_state != S_IDLE);
         timer     <= (next_state != state) ? 16'd0 : timer + 16'd1;
         case (state)
            S_ARB: begin
               if (win_vld) begin
                  grant        <= NUM_CH'(1) << win_idx;
                  channel      <= win_idx;
                  eng_cmd      <= win_cmd;
                  eng_wdata    <= win_wdata;
                  ptr          <= (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
                  verify_phase <= 1'b0;
                  verify_pend  <= 1'b0;
               end
            end
            S_WAIT: begin
               if (eng_done) begin
                  res_data <= eng_cmd[7] ? eng_rdata : 8'h00;
                  res_err  <= verify_phase && (eng_rdata != eng_wdata);
               end else if (timer == TO_LAST) begin
                  res_data <= 8'h00;
                  res_err  <= 1'b1;
               end
            end
            S_CS_HOLD: begin
               if (verify_needed) begin
                  verify_pend <= 1'b1;
               end else begin
                  ack      <= NUM_CH'(1) << channel;
                  rsp_data <= res_data;
                  rsp_err  <= res_err;
               end
            end
            S_GAP: begin
               if (verify_pend && (timer == GAP_LAST)) begin
                  verify_pend  <= 1'b0;
                  verify_phase <= 1'b1;
                  eng_cmd[7]   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_agc_sequencer.sv
// Testbench for spi_agc_sequencer: behavioural SPI device model plus a
// transaction-level reference model (register image, round-robin pointer,
// timeout rule, optional verify read) driven by directed and random traffic.
module tb_spi_agc_sequencer;
   localparam int NUM_CH         = 3;
   localparam int GAP_CYCLES     = 4;
   localparam int TIMEOUT_CYCLES = 20;
   localparam int CH_W           = $clog2(NUM_CH);
`ifdef AGC_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic                spi_clk = 1'b0;
   logic                reg_reset = 1'b0;
   logic [NUM_CH-1:0]   req = '0;
   logic [NUM_CH-1:0]   req_r1w0 = '0;
   logic [NUM_CH*7-1:0] req_addr = '0;
   logic [NUM_CH*8-1:0] req_wdata = '0;
   logic [NUM_CH-1:0]   grant;
   logic [NUM_CH-1:0]   ack;
   logic [CH_W-1:0]     channel;
   logic [7:0]          rsp_data;
   logic                rsp_err;
   logic                busy;
   logic                spi_cs;
   logic                eng_start;
   logic [7:0]          eng_cmd;
   logic [7:0]          eng_wdata;
   logic                eng_r1w0;
   logic                eng_done;
   logic [7:0]          eng_rdata = '0;
   logic                eng_done_m = 1'b0;
   logic                stray_done = 1'b0;

   assign eng_done = eng_done_m | stray_done;

   int         n_checks = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         n_starts = 0;
   int         n_acks = 0;
   int         last_start = 0;
   int         cfg_lat = 1;
   logic [7:0] cfg_xor = '0;
   logic [7:0] ref_mem [128];
   int         ref_ptr = 0;

   spi_agc_sequencer #(
      .NUM_CH(NUM_CH), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .spi_clk(spi_clk), .reg_reset(reg_reset), .req(req), .req_r1w0(req_r1w0),
      .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .ack(ack),
      .channel(channel), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
      .spi_cs(spi_cs), .eng_start(eng_start), .eng_cmd(eng_cmd),
      .eng_wdata(eng_wdata), .eng_r1w0(eng_r1w0), .eng_done(eng_done),
      .eng_rdata(eng_rdata)
   );

   always #5 spi_clk = ~spi_clk;

   always @(posedge spi_clk) cyc <= cyc + 1;

   always @(negedge spi_clk) begin
      if (eng_start) begin
         n_starts   <= n_starts + 1;
         last_start <= cyc;
      end
      if (ack != '0) n_acks <= n_acks + 1;
   end

   // SPI device: register file answering each engine transaction after cfg_lat
   // cycles (0 = never answers); reads are XORed with cfg_xor
   initial begin : engine
      logic [7:0] emem [128];
      logic [7:0] c, w;
      int         l;
      for (int i = 0; i < 128; i++) emem[i] = 8'(i * 37 + 11);
      forever begin
         @(negedge spi_clk);
         if (eng_start) begin
            c = eng_cmd; w = eng_wdata; l = cfg_lat;
            if (l > 0) begin
               repeat (l) @(posedge spi_clk);
               #1;
               if (c[7]) eng_rdata = emem[c[6:0]] ^ cfg_xor;
               else begin
                  emem[c[6:0]] = w;
                  eng_rdata = 8'($urandom);
               end
               eng_done_m = 1'b1;
               @(posedge spi_clk);
               #1 eng_done_m = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycles %0d required below 100000", cyc);
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NUM_CH-1:0] mask, input int p);
      for (int k = 0; k < NUM_CH; k++)
         if (mask[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
      return -1;
   endfunction

   // Expected outcome of one transaction; updates the register image
   task automatic model_txn(input bit rd, input logic [6:0] a, input logic [7:0] wd,
                            input int lat, input logic [7:0] x,
                            output logic [7:0] ed, output bit ee,
                            output int starts, output int wait_len);
      bit ok;
      ok       = (lat >= 1) && (lat <= TIMEOUT_CYCLES);
      starts   = 1;
      wait_len = ok ? lat : TIMEOUT_CYCLES;
      if (!ok) begin
         ed = 8'h00; ee = 1'b1;
         if (!rd && lat > 0) ref_mem[a] = wd;
      end else if (rd) begin
         ed = ref_mem[a] ^ x; ee = 1'b0;
      end else begin
         ref_mem[a] = wd;
         if (RB) begin
            starts = 2; ed = wd ^ x; ee = (x != 8'h00);
         end else begin
            ed = 8'h00; ee = 1'b0;
         end
      end
   endtask

   task automatic wait_grant();
      for (int i = 0; i < 30; i++) begin
         @(negedge spi_clk);
         if (grant != '0) break;
      end
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 3 * (TIMEOUT_CYCLES + GAP_CYCLES) + 40; i++) begin
         @(negedge spi_clk);
         if (ack != '0) break;
      end
   endtask

   // Counts busy cycles from the ack cycle on, and chip-select lows among them
   task automatic check_gap(input logic [7:0] ed);
      int gl, cslow;
      gl = 0; cslow = 0;
      while (busy && gl < GAP_CYCLES + 10) begin
         if (!spi_cs) cslow++;
         gl++;
         @(negedge spi_clk);
      end
      check_val("gap_len", gl, GAP_CYCLES);
      check_val("gap_cs_low", cslow, 0);
      check_val("rsp_hold", rsp_data, ed);
   endtask

   task automatic run_txn(input int ch, input bit rd, input logic [6:0] a,
                          input logic [7:0] wd, input int lat, input logic [7:0] x);
      logic [7:0] ed;
      bit         ee;
      int         es, ew, s0, a0;
      model_txn(rd, a, wd, lat, x, ed, ee, es, ew);
      @(negedge spi_clk);
      cfg_lat = lat; cfg_xor = x;
      req_r1w0[ch] = rd; req_addr[ch*7 +: 7] = a; req_wdata[ch*8 +: 8] = wd;
      req[ch] = 1'b1;
      s0 = n_starts; a0 = n_acks;
      wait_grant();
      check_val("grant", grant, 1 << ch);
      check_val("channel", channel, ch);
      check_val("eng_cmd", eng_cmd, {rd, a});
      check_val("eng_wdata", eng_wdata, wd);
      check_val("eng_r1w0", eng_r1w0, rd);
      req[ch] = 1'b0;
      ref_ptr = (ch + 1) % NUM_CH;
      wait_ack();
      check_val("ack", ack, 1 << ch);
      check_val("rsp_data", rsp_data, ed);
      check_val("rsp_err", rsp_err, ee);
      check_val("eng_starts", n_starts - s0, es);
      check_val("wait_len", cyc - last_start - 2, ew);
      check_gap(ed);
      check_val("ack_count", n_acks - a0, 1);
   endtask

   // All channels in mask request reads continuously for n grants
   task automatic run_rr(input logic [NUM_CH-1:0] mask, input int n, input int lat,
                         input logic [7:0] x);
      int exp_ch, gc, prev;
      prev = -1;
      @(negedge spi_clk);
      cfg_lat = lat; cfg_xor = x;
      for (int c = 0; c < NUM_CH; c++) begin
         req_r1w0[c] = 1'b1; req_addr[c*7 +: 7] = 7'(16 + c);
      end
      req = mask;
      for (int t = 0; t < n; t++) begin
         exp_ch = rr_pick(mask, ref_ptr);
         wait_grant();
         gc = cyc;
         check_val("rr_grant", grant, 1 << exp_ch);
         if (prev >= 0) check_val("rr_spacing", gc - prev, 5 + GAP_CYCLES + lat);
         prev = gc;
         ref_ptr = (exp_ch + 1) % NUM_CH;
         if (t == n - 1) req = '0;
         wait_ack();
         check_val("rr_ack", ack, 1 << exp_ch);
         check_val("rr_rdata", rsp_data, ref_mem[16 + exp_ch] ^ x);
         check_val("rr_err", rsp_err, 0);
      end
      for (int i = 0; i < GAP_CYCLES + 10 && busy; i++) @(negedge spi_clk);
   endtask

   initial begin : main
      int g, a0, cnt_start, cnt_cs, cnt_busy;
      for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i * 37 + 11);

      // Reset state
      repeat (3) @(negedge spi_clk);
      check_val("rst_spi_cs", spi_cs, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_grant", grant, 0);
      check_val("rst_ack", ack, 0);
      check_val("rst_eng_start", eng_start, 0);
      check_val("rst_rsp", {rsp_err, rsp_data}, 0);
      check_val("rst_eng_cmd", {eng_cmd, eng_wdata}, 0);
      check_val("rst_channel", channel, 0);
      reg_reset = 1'b1;

      // Idle: nothing happens without requests
      cnt_start = 0; cnt_cs = 0; cnt_busy = 0;
      repeat (50) begin
         @(negedge spi_clk);
         if (eng_start) cnt_start++;
         if (!spi_cs) cnt_cs++;
         if (busy) cnt_busy++;
      end
      check_val("idle_starts", cnt_start, 0);
      check_val("idle_cs_low", cnt_cs, 0);
      check_val("idle_busy", cnt_busy, 0);

      // Directed write, write-then-read, fairness
      run_txn(0, 1'b0, 7'h12, 8'h5A, 16, 8'h00);
      run_txn(2, 1'b0, 7'h05, 8'hC3, 3, 8'h00);
      run_txn(1, 1'b1, 7'h05, 8'h00, 5, 8'h00);
      run_rr(3'b011, 6, 4, 8'h00);

      // Request withdrawn while in ARB: no grant
      @(negedge spi_clk);
      req[2] = 1'b1;
      @(negedge spi_clk);
      check_val("wd_busy_arb", busy, 1);
      req[2] = 1'b0;
      g = 0;
      repeat (10) begin
         @(negedge spi_clk);
         if (grant != '0) g++;
      end
      check_val("wd_grants", g, 0);
      check_val("wd_busy_after", busy, 0);

      // Engine done outside WAIT is ignored
      a0 = n_acks;
      @(negedge spi_clk); stray_done = 1'b1;
      @(negedge spi_clk); stray_done = 1'b0;
      repeat (5) @(negedge spi_clk);
      check_val("stray_acks", n_acks - a0, 0);
      check_val("stray_busy", busy, 0);

      // Timeout, done on final timeout cycle, done one cycle late
      run_txn(1, 1'b0, 7'h33, 8'h77, 0, 8'h00);
      run_txn(0, 1'b1, 7'h12, 8'h00, TIMEOUT_CYCLES, 8'h00);
      run_txn(2, 1'b0, 7'h40, 8'h99, TIMEOUT_CYCLES + 1, 8'h00);
      run_txn(1, 1'b1, 7'h40, 8'h00, 2, 8'h00);

      // Readback mismatch case (0x5A written, 0x5B read back)
      run_txn(0, 1'b0, 7'h21, 8'h5A, 4, 8'h01);

      // Reset in WAIT
      @(negedge spi_clk);
      cfg_lat = 0;
      req_r1w0[0] = 1'b0; req_addr[6:0] = 7'h44; req_wdata[7:0] = 8'h11;
      req[0] = 1'b1;
      wait_grant();
      check_val("mr_grant", grant, 1);
      req[0] = 1'b0;
      repeat (6) @(negedge spi_clk);
      check_val("mr_cs_before", spi_cs, 0);
      a0 = n_acks;
      #2 reg_reset = 1'b0;
      #1;
      check_val("mr_cs_async", spi_cs, 1);
      check_val("mr_busy_async", busy, 0);
      ref_ptr = 0;
      @(negedge spi_clk);
      reg_reset = 1'b1;
      repeat (25) @(negedge spi_clk);
      check_val("mr_no_ack", n_acks - a0, 0);
      run_rr(3'b011, 1, 3, 8'h00);

      // Random single-channel traffic
      for (int t = 0; t < 40; t++) begin
         int         ch, lat;
         bit         rd;
         logic [7:0] x;
         ch  = $urandom_range(0, NUM_CH - 1);
         rd  = 1'($urandom);
         lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT_CYCLES + 5);
         x   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         run_txn(ch, rd, 7'($urandom), 8'($urandom), lat, x);
      end

      // Random contention
      run_rr(3'b111, 5, 2, 8'h00);
      run_rr(3'b101, 4, $urandom_range(1, 6), 8'h00);
      run_rr(3'b110, 3, 1, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
